overlay_config_loader: RTL

//  Master end of the overlay scan-chain configuration interface. Takes config words from the host

---
 rtl/overlay_config_loader_pkg.sv | 36 +++
 rtl/overlay_config_loader_serializer.sv | 84 ++++++++
 rtl/overlay_config_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/overlay_config_loader_pkg.sv
// Shared types and elaboration-time helpers for the overlay scan-chain configuration loader.
// Covers FSM state encodings, default geometry and chain-length arithmetic.
package overlay_config_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_CHAIN_LEN = 1024;
    localparam int DEF_CNT_W     = 11;

    // Scan cells contributed by one tile's logic block, connection box and switch box.
    localparam int TILE_LB_BITS = 20;
    localparam int TILE_CB_BITS = 24;
    localparam int TILE_SB_BITS = 20;

    function automatic int chain_len_calc(input int lb_bits, input int cb_bits,
                                          input int sb_bits, input int tiles);
        return (lb_bits + cb_bits + sb_bits) * tiles;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Bits carried by the final host word; a whole word when the chain divides evenly.
    function automatic int tail_bits(input int chain_len, input int word_w);
        int rem;
        rem = chain_len % word_w;
        return (rem == 0) ? word_w : rem;
    endfunction

endpackage

// File: rtl/overlay_config_loader_serializer.sv
// Word-to-bit serializer: a shift register fed from one holding register so word
// boundaries shift without a bubble. Emits one bit per cycle while enabled and non-empty.
module overlay_config_loader_serializer
    import overlay_config_loader_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift,
    output logic              bit_out
);

    localparam int NUM_WORDS = ceil_div(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = tail_bits(CHAIN_LEN, WORD_W);
    localparam int LEN_W     = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] WORD_LIMIT = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_WORDS - 1);
    localparam logic [LEN_W-1:0] FULL_LEN   = LEN_W'(WORD_W);
    localparam logic [LEN_W-1:0] TAIL_LEN   = LEN_W'(LAST_BITS);
    localparam logic [LEN_W-1:0] ONE_LEFT   = LEN_W'(1);

    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] hr;
    logic [LEN_W-1:0]  sr_left;
    logic [LEN_W-1:0]  hr_len;
    logic              hr_full;
    logic [CNT_W-1:0]  words_taken;

    logic              xfer;
    logic [LEN_W-1:0]  xfer_len;
    logic              sr_drained;

    assign in_ready   = enable & ~hr_full & (words_taken < WORD_LIMIT);
    assign xfer       = in_valid & in_ready;
    // The last word only contributes its low tail bits; the rest are never shifted out.
    assign xfer_len   = (words_taken == LAST_IDX) ? TAIL_LEN : FULL_LEN;
    assign shift      = enable & (sr_left != '0);
    assign bit_out    = sr[0];
    assign sr_drained = (sr_left == '0) | (shift & (sr_left == ONE_LEFT));

    always_ff @(posedge clk) begin
        // NOTE: the data registers are cleared along with their flags so an abandoned load never leaves stale bits to shift later.
        if (rst || clear) begin
            sr          <= '0;
            hr          <= '0;
            sr_left     <= '0;
            hr_len      <= '0;
            hr_full     <= 1'b0;
            words_taken <= '0;
        end else begin
            if (xfer) begin
                words_taken <= words_taken + 1'b1;
            end
            if (shift) begin
                sr      <= sr >> 1;
                sr_left <= sr_left - 1'b1;
            end
            if (sr_drained) begin
                if (hr_full) begin
                    sr      <= hr;
                    sr_left <= hr_len;
                    hr_full <= 1'b0;
                end else if (xfer) begin
                    sr      <= in_data;
                    sr_left <= xfer_len;
                end
            end else if (xfer) begin
                hr      <= in_data;
                hr_len  <= xfer_len;
                hr_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/overlay_config_loader.sv
// Scan-chain configuration master: drives SE/SOUT from host words, captures the chain
// tail on SIN into readback words, and tracks load progress through IDLE/RUN/DONE.
module overlay_config_loader
    import overlay_config_loader_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              PCLK,
    input  logic              PRST,
    input  logic              START,
    input  logic [WORD_W-1:0] CFG_DATA,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    output logic              SE,
    output logic              SOUT,
    input  logic              SIN,
    output logic [WORD_W-1:0] RB_DATA,
    output logic              RB_VALID,
    output logic              BUSY,
    output logic              DONE
);

    localparam int RB_PAD   = WORD_W - tail_bits(CHAIN_LEN, WORD_W);
    localparam int RB_CNT_W = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0]    CHAIN_END = CNT_W'(CHAIN_LEN);
    localparam logic [RB_CNT_W-1:0] RB_LAST   = RB_CNT_W'(WORD_W - 1);

    loader_state_e     state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              se_q;
    logic              sout_q;
    logic              busy_q;
    logic              done_q;
    logic [WORD_W-1:0] rb_sr;
    logic [RB_CNT_W-1:0] rb_cnt;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;

    logic              run;
    logic              start_ok;
    logic              shift;
    logic              bit_out;
    logic [WORD_W-1:0] rb_next;

    assign run      = (state == ST_RUN);
    assign start_ok = START & ((state == ST_IDLE) | (state == ST_DONE));
    assign rb_next  = {SIN, rb_sr[WORD_W-1:1]};

    overlay_config_loader_serializer #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_serializer (
        .clk      (PCLK),
        .rst      (PRST),
        .clear    (start_ok),
        .enable   (run),
        .in_data  (CFG_DATA),
        .in_valid (CFG_VALID),
        .in_ready (CFG_READY),
        .shift    (shift),
        .bit_out  (bit_out)
    );

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            se_q       <= 1'b0;
            sout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rb_sr      <= '0;
            rb_cnt     <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;

            // SE/SOUT are launched at the edge that schedules a shift, so the chain sees them stable a full cycle.
            se_q <= shift;
            if (shift) begin
                sout_q  <= bit_out;
                bit_cnt <= bit_cnt + 1'b1;
            end

            // bit_cnt still counts the bit being captured here, so reaching CHAIN_END marks the final capture.
            if (se_q) begin
                if (bit_cnt == CHAIN_END) begin
                    rb_data_q  <= rb_next >> RB_PAD;
                    rb_valid_q <= 1'b1;
                    rb_sr      <= '0;
                    rb_cnt     <= '0;
                end else if (rb_cnt == RB_LAST) begin
                    rb_data_q  <= rb_next;
                    rb_valid_q <= 1'b1;
                    rb_sr      <= rb_next;
                    rb_cnt     <= '0;
                end else begin
                    rb_sr  <= rb_next;
                    rb_cnt <= rb_cnt + 1'b1;
                end
            end

            // NOTE: all state here uses <=; the restart clears below are placed last so they win over any update above.
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state   <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        bit_cnt <= '0;
                        rb_sr   <= '0;
                        rb_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (bit_cnt == CHAIN_END) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign SE       = se_q;
    assign SOUT     = sout_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RB_DATA  = rb_data_q;
    assign RB_VALID = rb_valid_q;

endmodule
